uart_tx_buffer: RTL

- Consumer end of the debug character stream: accepts 8-bit ASCII characters over a valid/busy handshake, buffers them in a FIFO and serializes them as 8N1 UART frames on a single TX line.
- Sits between debug_ctrl-style producers and the board UART pin. The simulation char tap can observe accepted characters.

---
 rtl/uart_defs.sv | 22 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_buffer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_defs.sv
// Shared UART framing definitions: FSM state encoding, line levels and clog2.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_defs;
    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
`endif

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO, 2**DEPTH_LOG2 entries, async active-high reset.
// dout shows the head entry combinationally; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered UART transmitter: FIFO-fed 8N1 serializer with registered tx line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_buffer
    import uart_defs::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          char_in,
    input  logic                char_valid,
    output logic                busy,
    output logic                tx,
    output logic                tx_active,
    output logic [DEPTH_LOG2:0] fifo_count
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = clog2(DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_buffer: CLK_FREQ/BAUD must be at least 2");
        end
        if (DEPTH_LOG2 < 1) begin : g_bad_depth
            $error("uart_tx_buffer: DEPTH_LOG2 must be at least 1");
        end
    endgenerate

    logic       fifo_pop, fifo_empty;
    logic [7:0] fifo_dout;

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (char_valid),
        .pop   (fifo_pop),
        .din   (char_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (busy),
        .empty (fifo_empty)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             active_q, active_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             baud_end;

    assign baud_end  = (baud_q == BAUD_LAST);
    assign tx        = tx_q;
    assign tx_active = active_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        // Line outputs follow the current state one cycle later, so every
        // bit still lasts exactly DIV cycles on the pin.
        case (state_q)
            ST_START:  tx_d = START_LVL;
            ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            ST_STOP:   tx_d = STOP_LVL;
            default:   tx_d = IDLE_LVL;
        endcase
        active_d = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    par_d    = ^fifo_dout;
`endif
                    baud_d   = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        par_d    = ^fifo_dout;
`endif
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= IDLE_LVL;
            active_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            active_q <= active_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end
endmodule
